// File: rtl/ahb_burst_master.sv
// AHB-Lite master issuing one SINGLE/INCR burst per command with pipelined address/data phases.
// Define AHB_MASTER_ERR_ABORT_EN to abandon the remaining beats of a burst on an ERROR response.
module ahb_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BEATS  = 16,
  localparam int BW        = $clog2(MAX_BEATS + 1)
) (
  input  logic                  HCLK,
  input  logic                  RESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [BW-1:0]         cmd_beats,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

`ifdef AHB_MASTER_ERR_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  localparam logic [2:0] MAX_SIZE  = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [1:0]            htrans_q, htrans_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [2:0]            hburst_q, hburst_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  err_q, err_d;
  logic [BW-1:0]         left_q, left_d;
  logic                  dphase_q, dphase_d;

  logic [2:0]            size_clamped;
  logic [BW-1:0]         beats_eff;
  logic                  abort_now;

  assign size_clamped = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
  assign beats_eff    = (cmd_beats == '0) ? BW'(1) : cmd_beats;
  // First wait-state cycle of an ERROR response; only acted on when aborting is enabled.
  assign abort_now    = ABORT_EN && dphase_q && HRESP && !HREADY;

  always_ff @(posedge HCLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      haddr_q    <= '0;
      htrans_q   <= TR_IDLE;
      hwrite_q   <= 1'b0;
      hsize_q    <= 3'b010;
      hburst_q   <= 3'b000;
      hwdata_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      left_q     <= '0;
      dphase_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hburst_q   <= hburst_d;
      hwdata_q   <= hwdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      left_q     <= left_d;
      dphase_q   <= dphase_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hburst_d   = hburst_q;
    hwdata_d   = hwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    left_d     = left_q;
    wr_pop     = 1'b0;

    // A data phase follows every completed address phase and lasts until HREADY.
    if (HREADY) dphase_d = (state_q == S_ADDR) && htrans_q[1];
    else        dphase_d = dphase_q;

    if (dphase_q && HRESP) err_d = 1'b1;

    if (dphase_q && HREADY && !hwrite_q && !(ABORT_EN && HRESP)) begin
      rd_data_d  = HRDATA;
      rd_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          haddr_d  = cmd_addr;
          htrans_d = TR_NONSEQ;
          hwrite_d = cmd_write;
          hsize_d  = size_clamped;
          hburst_d = (beats_eff == BW'(1)) ? 3'b000 : 3'b001;
          left_d   = beats_eff;
          err_d    = 1'b0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (abort_now) begin
          htrans_d = TR_IDLE;
          state_d  = S_DRAIN;
        end else if (HREADY) begin
          if (hwrite_q) begin
            wr_pop   = 1'b1;
            hwdata_d = wr_data;
          end
          if (left_q > BW'(1)) begin
            haddr_d  = haddr_q + (ADDR_WIDTH'(1) << hsize_q);
            htrans_d = TR_SEQ;
            left_d   = left_q - BW'(1);
          end else begin
            htrans_d = TR_IDLE;
            state_d  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (HREADY) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_ADDR) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = hburst_q;
  assign HWDATA    = hwdata_q;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Bench for ahb_burst_master: a reactive AHB slave plus a per-command transfer model.
module tb_ahb_burst_master;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          HCLK = 1'b0;
  logic          RESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_size;
  logic [4:0]    cmd_beats;
  logic [DW-1:0] wr_data, rd_data, HWDATA, HRDATA;
  logic          wr_pop, rd_valid, done, err, busy;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]    HSIZE, HBURST;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [0:16];
  logic [31:0] q_exp[$];
  logic [31:0] q_obs[$];

  always #5 HCLK = ~HCLK;

  ahb_burst_master dut (
    .HCLK(HCLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_beats(cmd_beats),
    .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HMASTLOCK(HMASTLOCK),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  task automatic check_reset_values(input string name);
    checks++;
    if (HADDR !== 0 || HWDATA !== 0 || HTRANS !== 2'b00 || HWRITE !== 0 || HSIZE !== 3'b010 ||
        HBURST !== 3'b000 || rd_data !== 0 || rd_valid !== 0 || wr_pop !== 0 || done !== 0 ||
        err !== 0 || busy !== 0 || cmd_ready !== 1 || HMASTLOCK !== 0) begin
      errors++;
      $display("FAIL %s reset_values: got haddr=%h htrans=%b hsize=%b hburst=%b hwdata=%h rd=%h rv=%b pop=%b done=%b err=%b busy=%b rdy=%b, need 0/00/010/000/0/0/0/0/0/0/0/1",
               name, HADDR, HTRANS, HSIZE, HBURST, HWDATA, rd_data, rd_valid, wr_pop, done, err, busy, cmd_ready);
    end
  endtask

  // Drives one command, acts as the slave, and checks the bus against the burst the command describes.
  task automatic run_cmd(input string name, input logic [31:0] addr, input logic wr,
                         input logic [2:0] size, input logic [4:0] beats, input int wait_pct,
                         input int stall_beat, input int err_beat, input int rst_cyc,
                         input bit ignore_t, input logic [31:0] wd0, input bit seq_rd);
    int eff_beats, esz, inc, exp_ap, exp_rd, exp_done;
    bit abort, exp_err, dp_active, finished, first_err_prev, p_valid, exp_busy;
    int n_ap, pops, done_cnt, done_cyc, last_dp, first_ap, dp_idx, err_st, stall_left;
    logic [1:0] p_htrans;
    logic [31:0] p_haddr, exp_a;
    logic p_hready;
`ifdef AHB_MASTER_ERR_ABORT_EN
    abort = 1'b1;
`else
    abort = 1'b0;
`endif
    eff_beats = (beats == 0) ? 1 : int'(beats);
    esz       = (size > 2) ? 2 : int'(size);
    inc       = 1 << esz;
    exp_err   = (err_beat != 0) && (err_beat <= eff_beats);
    exp_ap    = (abort && exp_err) ? err_beat : eff_beats;
    exp_rd    = wr ? 0 : ((abort && exp_err) ? err_beat - 1 : eff_beats);
    exp_done  = eff_beats + 2 + ((stall_beat != 0 && stall_beat <= eff_beats) ? 2 : 0);
    n_ap = 0; pops = 0; done_cnt = 0; done_cyc = -1; last_dp = -1; first_ap = -1;
    dp_active = 0; dp_idx = 0; err_st = 0; stall_left = 2; finished = 0;
    first_err_prev = 0; p_valid = 0; p_htrans = 0; p_haddr = 0; p_hready = 1;
    for (int i = 0; i < 17; i++) wd[i] = $urandom;
    wd[0] = wd0;
    q_exp.delete();
    q_obs.delete();

    @(negedge HCLK);
    cmd_valid = 1; cmd_addr = addr; cmd_write = wr; cmd_size = size; cmd_beats = beats;
    HREADY = 1; HRESP = 0; wr_data = wd[0];
    #1;
    checks++;
    if (cmd_ready !== 1) begin
      errors++;
      $display("FAIL %s accept: cmd_ready=%b need 1", name, cmd_ready);
    end

    for (int c = 1; c < 400 && !finished; c++) begin
      @(negedge HCLK);
      if (ignore_t) begin
        cmd_valid = 1; cmd_addr = $urandom; cmd_write = 1'($urandom);
        cmd_size = 3'($urandom); cmd_beats = 5'($urandom);
      end else begin
        cmd_valid = 0;
      end
      if (dp_active) begin
        if (dp_idx + 1 == err_beat) begin
          HRESP = 1; HREADY = (err_st != 0); err_st++;
        end else if (dp_idx + 1 == stall_beat && stall_left > 0) begin
          HRESP = 0; HREADY = 0; stall_left--;
        end else begin
          HRESP = 0; HREADY = ($urandom_range(99) >= wait_pct);
        end
        HRDATA = seq_rd ? 32'(dp_idx + 1) : $urandom;
      end else begin
        HRESP = 0; HREADY = 1; HRDATA = $urandom;
      end
      wr_data = wd[pops];
      #1;

      if (rd_valid === 1) q_obs.push_back(rd_data);
      if (wr_pop === 1) pops++;
      if (done === 1) begin done_cnt++; done_cyc = c; end

      exp_busy = (done !== 1);
      checks++;
      if (busy !== exp_busy || cmd_ready !== 0) begin
        errors++;
        $display("FAIL %s busy@%0d: busy=%b rdy=%b need busy=%b rdy=0", name, c, busy, cmd_ready, exp_busy);
      end

      if (abort && first_err_prev) begin
        checks++;
        if (HTRANS !== 2'b00) begin
          errors++;
          $display("FAIL %s abort_idle@%0d: HTRANS=%b need 00", name, c, HTRANS);
        end
      end else if (p_valid && p_htrans[1] && !p_hready) begin
        checks++;
        if (HTRANS !== p_htrans || HADDR !== p_haddr) begin
          errors++;
          $display("FAIL %s hold@%0d: HTRANS=%b HADDR=%h need %b %h", name, c, HTRANS, HADDR, p_htrans, p_haddr);
        end
      end
      first_err_prev = dp_active && HRESP && !HREADY;

      if (dp_active && HREADY) begin
        last_dp = c;
        if (wr) begin
          checks++;
          if (HWDATA !== wd[dp_idx]) begin
            errors++;
            $display("FAIL %s hwdata beat %0d: got %h need %h", name, dp_idx, HWDATA, wd[dp_idx]);
          end
        end else if (!(abort && HRESP)) begin
          q_exp.push_back(HRDATA);
        end
        dp_active = 0;
      end

      if (HTRANS[1] === 1'b1 && HREADY) begin
        exp_a = addr + 32'(n_ap * inc);
        checks++;
        if (n_ap >= exp_ap || HADDR !== exp_a || HTRANS !== ((n_ap == 0) ? 2'b10 : 2'b11) ||
            HSIZE !== 3'(esz) || HBURST !== ((eff_beats == 1) ? 3'b000 : 3'b001) || HWRITE !== wr) begin
          errors++;
          $display("FAIL %s addr_phase %0d: got a=%h t=%b s=%b b=%b w=%b need a=%h s=%0d beats=%0d w=%b (max %0d phases)",
                   name, n_ap, HADDR, HTRANS, HSIZE, HBURST, HWRITE, exp_a, esz, eff_beats, wr, exp_ap);
        end
        if (n_ap == 0) first_ap = c;
        dp_active = 1;
        dp_idx = n_ap;
        n_ap++;
      end
      p_valid = 1; p_htrans = HTRANS; p_haddr = HADDR; p_hready = HREADY;

      if (rst_cyc != 0 && c == rst_cyc) begin
        #1 RESET = 0;
        #1 check_reset_values({name, "_async"});
        cmd_valid = 0; HREADY = 1; HRESP = 0;
        for (int k = 0; k < 3; k++) begin
          @(negedge HCLK); #1;
          checks++;
          if (done !== 0 || wr_pop !== 0 || rd_valid !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL %s in_reset: done=%b pop=%b rv=%b busy=%b need 0", name, done, wr_pop, rd_valid, busy);
          end
        end
        @(negedge HCLK) RESET = 1;
        $display("txn %s addr=%h wr=%0d beats=%0d reset at cycle %0d", name, addr, wr, eff_beats, c);
        return;
      end
      if (done === 1) finished = 1;
    end
    cmd_valid = 0;

    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: done not seen", name);
    end
    @(negedge HCLK);
    HREADY = 1; HRESP = 0;
    #1;
    checks++;
    if (done !== 0 || cmd_ready !== 1 || busy !== 0 || err !== exp_err) begin
      errors++;
      $display("FAIL %s after_done: done=%b rdy=%b busy=%b err=%b need 0 1 0 %b", name, done, cmd_ready, busy, err, exp_err);
    end
    checks++;
    if (done_cnt != 1 || n_ap != exp_ap || pops != (wr ? exp_ap : 0)) begin
      errors++;
      $display("FAIL %s counts: done=%0d aphases=%0d pops=%0d need 1 %0d %0d", name, done_cnt, n_ap, pops, exp_ap, wr ? exp_ap : 0);
    end
    checks++;
    if (first_ap != 1 || done_cyc != last_dp + 1) begin
      errors++;
      $display("FAIL %s latency: nonseq@%0d done@%0d last_data@%0d need nonseq@1 done@last+1", name, first_ap, done_cyc, last_dp);
    end
    if (wait_pct == 0 && err_beat == 0) begin
      checks++;
      if (done_cyc != exp_done) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d need %0d", name, done_cyc, exp_done);
      end
    end
    checks++;
    if (q_obs.size() != exp_rd || q_exp.size() != exp_rd) begin
      errors++;
      $display("FAIL %s rd_count: got %0d need %0d", name, q_obs.size(), exp_rd);
    end else begin
      for (int i = 0; i < exp_rd; i++) begin
        checks++;
        if (q_obs[i] !== q_exp[i]) begin
          errors++;
          $display("FAIL %s rd_data beat %0d: got %h need %h", name, i, q_obs[i], q_exp[i]);
        end
      end
    end
    $display("txn %s addr=%h wr=%0d size=%0d beats=%0d err=%0b done@%0d rd=%0d pops=%0d",
             name, addr, wr, esz, eff_beats, err, done_cyc, q_obs.size(), pops);
  endtask

  task automatic test_reset();
    RESET = 0; cmd_valid = 0; cmd_addr = 0; cmd_write = 0; cmd_size = 0; cmd_beats = 0;
    wr_data = 0; HRDATA = 0; HREADY = 1; HRESP = 0;
    #12 check_reset_values("reset");
    @(negedge HCLK) RESET = 1;
    $display("txn reset released");
  endtask

  task automatic test_single_write();
    run_cmd("single_write", 32'h100, 1'b1, 3'd2, 5'd1, 0, 0, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_incr_read();
    run_cmd("incr_read", 32'h200, 1'b0, 3'd2, 5'd4, 0, 0, 0, 0, 1'b0, $urandom, 1'b1);
  endtask

  task automatic test_wait_states();
    run_cmd("wait_states", 32'h200, 1'b0, 3'd2, 5'd4, 0, 2, 0, 0, 1'b0, $urandom, 1'b1);
  endtask

  task automatic test_halfword_write();
    run_cmd("halfword_write", 32'h10, 1'b1, 3'd1, 5'd3, 0, 0, 0, 0, 1'b1, $urandom, 1'b0);
  endtask

  task automatic test_error();
    run_cmd("error_read", 32'h300, 1'b0, 3'd2, 5'd4, 0, 0, 2, 0, 1'b0, $urandom, 1'b1);
    run_cmd("error_write", 32'h400, 1'b1, 3'd2, 5'd4, 0, 0, 3, 0, 1'b0, $urandom, 1'b0);
  endtask

  task automatic test_corner_cmds();
    run_cmd("zero_beats", 32'h40, 1'b0, 3'd0, 5'd0, 0, 0, 0, 0, 1'b0, $urandom, 1'b0);
    run_cmd("size_clamp_wrap", 32'hFFFF_FFF8, 1'b1, 3'd3, 5'd4, 0, 0, 0, 0, 1'b0, $urandom, 1'b0);
  endtask

  task automatic test_reset_mid();
    run_cmd("reset_mid", 32'h500, 1'b0, 3'd2, 5'd4, 0, 0, 0, 3, 1'b1, $urandom, 1'b0);
    run_cmd("after_reset", 32'h600, 1'b1, 3'd2, 5'd4, 0, 0, 0, 0, 1'b0, $urandom, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 20; n++) begin
      logic [31:0] a;
      logic [4:0]  b;
      logic [2:0]  s;
      int          eb, e;
      s = 3'($urandom_range(3));
      b = 5'($urandom_range(16));
      e = (b == 0) ? 1 : int'(b);
      a = $urandom;
      a[2:0] = 3'b000;
      if (n % 5 == 0) a[31:8] = '1;
      eb = ($urandom_range(3) == 0) ? $urandom_range(e, 1) : 0;
      run_cmd($sformatf("rand%0d", n), a, 1'($urandom), s, b, 30, 0, eb, 0,
              1'($urandom), $urandom, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr_read();
    test_wait_states();
    test_halfword_write();
    test_error();
    test_corner_cmds();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
